contador_ciclos: RTL and testbench



---
 rtl/contador_ciclos.sv | 129 ++++++++++++
 tb/tb_contador_ciclos.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_ciclos.sv
// Counts completed interval-timer expiries, owns the timer's clear line,
// and closes a production batch with a one-cycle pulse after META intervals.
module contador_ciclos #(
  parameter int unsigned META      = 10,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned REARM_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clr_cnt,
  input  logic             tmr_done,
  output logic             tmr_clr,
  output logic [WIDTH-1:0] ciclos,
  output logic             running,
  output logic             lote_ok
);

  localparam int unsigned      ARM_W    = (REARM_LEN > 2) ? $clog2(REARM_LEN) : 1;
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(REARM_LEN - 1);
  localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);
  localparam logic [WIDTH-1:0] META_V   = WIDTH'(META);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } state_t;

  state_t           state;
  logic [ARM_W-1:0] arm_cnt;
  logic             tmr_done_q;
  logic             first_wait;
  logic [WIDTH-1:0] ciclos_inc;
  logic             expiry;

  // ciclos stays below META before an increment, so the sum never wraps
  assign ciclos_inc = ciclos + CNT_ONE;
  // The first WAIT cycle may still see a stale expiry from before the re-arm
  assign expiry     = (state == WAIT) && tmr_done_q && !first_wait;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmr_clr    <= 1'b1;
      ciclos     <= '0;
      running    <= 1'b0;
      lote_ok    <= 1'b0;
      tmr_done_q <= 1'b0;
      arm_cnt    <= '0;
      first_wait <= 1'b0;
    end else begin
      tmr_done_q <= tmr_done;
      lote_ok    <= 1'b0;
      first_wait <= 1'b0;

      if (stop) begin
        state   <= IDLE;
        tmr_clr <= 1'b1;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (clr_cnt) ciclos <= '0;
            if (start) begin
              state   <= ARM;
              arm_cnt <= ARM_LOAD;
            end
          end

          // Timer held cleared for REARM_LEN cycles, then released
          ARM: begin
            if (clr_cnt) ciclos <= '0;
            if (arm_cnt == '0) begin
              state      <= WAIT;
              tmr_clr    <= 1'b0;
              running    <= 1'b1;
              first_wait <= 1'b1;
            end else begin
              arm_cnt <= arm_cnt - ARM_ONE;
            end
          end

          WAIT: begin
            if (expiry) begin
              tmr_clr <= 1'b1;
              running <= 1'b0;
              if (clr_cnt) begin
                ciclos  <= '0;
                state   <= ARM;
                arm_cnt <= ARM_LOAD;
              end else if (ciclos_inc == META_V) begin
                ciclos  <= ciclos_inc;
                lote_ok <= 1'b1;
                state   <= FULL;
              end else begin
                ciclos  <= ciclos_inc;
                state   <= ARM;
                arm_cnt <= ARM_LOAD;
              end
            end else if (clr_cnt) begin
              ciclos <= '0;
            end
          end

          FULL: begin
            if (clr_cnt) begin
              ciclos <= '0;
            end else if (start) begin
              ciclos  <= '0;
              state   <= ARM;
              arm_cnt <= ARM_LOAD;
            end
          end

          default: begin
            state   <= IDLE;
            tmr_clr <= 1'b1;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_contador_ciclos.sv
// Bench for contador_ciclos: behavioural interval timer plus a cycle-level
// reference model of the batch counter, directed scenarios and random traffic.
module tb_contador_ciclos;

  localparam int unsigned META_T   = 3;
  localparam int unsigned W        = 16;
  localparam int unsigned REARM_T  = 2;
  localparam int          P_IDLE   = 0;
  localparam int          P_ARM    = 1;
  localparam int          P_WAIT   = 2;
  localparam int          P_FULL   = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         clr_cnt;
  logic         tmr_done = 1'b0;
  logic         tmr_clr;
  logic [W-1:0] ciclos;
  logic         running;
  logic         lote_ok;
  logic [W+2:0] act;

  int passed = 0;
  int total  = 0;

  contador_ciclos #(.META(META_T), .WIDTH(W), .REARM_LEN(REARM_T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr_cnt(clr_cnt),
    .tmr_done(tmr_done), .tmr_clr(tmr_clr), .ciclos(ciclos),
    .running(running), .lote_ok(lote_ok)
  );

  always #5 clk = ~clk;

  assign act = {tmr_clr, running, lote_ok, ciclos};

  // Behavioural interval timer: expires tdelay cycles after release, cleared by tmr_clr
  int tcnt   = 0;
  int tdelay = 8;
  always @(posedge clk) begin
    if (tmr_clr !== 1'b0) begin
      tcnt     <= 0;
      tmr_done <= 1'b0;
    end else if (!tmr_done) begin
      if (tcnt == tdelay - 1) tmr_done <= 1'b1;
      else tcnt <= tcnt + 1;
    end
  end

  // Reference model: phase, cycles of arming left, age within WAIT
  int           m_phase    = P_IDLE;
  int           m_arm_left = 0;
  int           m_age      = 0;
  logic [W-1:0] m_ciclos   = '0;
  logic         m_lote     = 1'b0;
  logic         m_done_q   = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase  <= P_IDLE;
      m_ciclos <= '0;
      m_lote   <= 1'b0;
      m_done_q <= 1'b0;
      m_age    <= 0;
    end else begin
      m_done_q <= tmr_done;
      m_lote   <= 1'b0;
      if (stop) begin
        m_phase <= P_IDLE;
      end else begin
        case (m_phase)
          P_IDLE: begin
            if (clr_cnt) m_ciclos <= '0;
            if (start) begin m_phase <= P_ARM; m_arm_left <= REARM_T; end
          end
          P_ARM: begin
            if (clr_cnt) m_ciclos <= '0;
            if (m_arm_left == 1) begin m_phase <= P_WAIT; m_age <= 0; end
            else m_arm_left <= m_arm_left - 1;
          end
          P_WAIT: begin
            m_age <= m_age + 1;
            if (m_done_q && m_age > 0) begin
              if (clr_cnt) begin
                m_ciclos <= '0; m_phase <= P_ARM; m_arm_left <= REARM_T;
              end else if (int'(m_ciclos) + 1 == int'(META_T)) begin
                m_ciclos <= m_ciclos + W'(1); m_lote <= 1'b1; m_phase <= P_FULL;
              end else begin
                m_ciclos <= m_ciclos + W'(1); m_phase <= P_ARM; m_arm_left <= REARM_T;
              end
            end else if (clr_cnt) begin
              m_ciclos <= '0;
            end
          end
          default: begin
            if (clr_cnt) m_ciclos <= '0;
            else if (start) begin m_ciclos <= '0; m_phase <= P_ARM; m_arm_left <= REARM_T; end
          end
        endcase
      end
    end
  end

  function automatic logic [W+2:0] exp_vec();
    return {m_phase != P_WAIT, m_phase == P_WAIT, m_lote, m_ciclos};
  endfunction

  function automatic logic expiry_pending();
    return (m_phase == P_WAIT) && m_done_q && (m_age > 0);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clr_cnt = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (act !== {3'b100, W'(0)}) $display("FAIL reset_idle[%0d]: got %h exp %h", i, act, {3'b100, W'(0)});
      else passed++;
    end
  endtask

  task automatic test_arm_timing();
    logic [1:0] seq [3] = '{2'b10, 2'b10, 2'b01};
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      start = 1'b0;
      total++;
      if ({tmr_clr, running} !== seq[i]) $display("FAIL arm_timing[%0d]: got %b exp %b", i, {tmr_clr, running}, seq[i]);
      else passed++;
    end
  endtask

  task automatic test_full_batch();
    int lotes = 0;
    int rise_i = -100;
    logic prev_done = tmr_done;
    logic [W-1:0] prev_c = ciclos;
    for (int i = 0; i < 80; i++) begin
      tick();
      total++;
      if (act !== exp_vec()) $display("FAIL full_batch[%0d]: got %h exp %h", i, act, exp_vec());
      else passed++;
      if (tmr_done && !prev_done) rise_i = i;
      if (ciclos != prev_c) begin
        total++;
        if (i - rise_i !== 2) $display("FAIL incr_latency: got %0d exp 2", i - rise_i);
        else passed++;
      end
      if (lote_ok) lotes++;
      prev_done = tmr_done;
      prev_c = ciclos;
    end
    total++;
    if ({lotes, act} !== {32'd1, 3'b100, W'(3)}) $display("FAIL batch_close: lotes %0d out %h exp 1 %h", lotes, act, {3'b100, W'(3)});
    else passed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (act !== {3'b100, W'(0)}) $display("FAIL restart: got %h exp %h", act, {3'b100, W'(0)});
    else passed++;
    repeat (2) tick();
    total++;
    if ({tmr_clr, running} !== 2'b01) $display("FAIL restart_arm: got %b exp 01", {tmr_clr, running});
    else passed++;
  endtask

  task automatic test_stop_resume();
    int lotes = 0;
    for (int i = 0; i < 100 && !(m_phase == P_WAIT && m_ciclos == 1); i++) begin
      tick();
      total++;
      if (act !== exp_vec()) $display("FAIL stop_wait[%0d]: got %h exp %h", i, act, exp_vec());
      else passed++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (act !== {3'b100, W'(1)}) $display("FAIL stop_idle: got %h exp %h", act, {3'b100, W'(1)});
    else passed++;
    repeat (5) tick();
    total++;
    if (act !== {3'b100, W'(1)}) $display("FAIL stop_hold: got %h exp %h", act, {3'b100, W'(1)});
    else passed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && m_phase != P_FULL; i++) begin
      tick();
      total++;
      if (act !== exp_vec()) $display("FAIL resume[%0d]: got %h exp %h", i, act, exp_vec());
      else passed++;
      if (lote_ok) lotes++;
    end
    total++;
    if ({lotes, ciclos} !== {32'd1, W'(3)}) $display("FAIL resume_close: lotes %0d ciclos %0d exp 1 3", lotes, ciclos);
    else passed++;
  endtask

  task automatic test_simultaneous();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !(expiry_pending() && m_ciclos == 2); i++) tick();
    total++;
    if (!(expiry_pending() && ciclos == 2)) $display("FAIL clr_expiry_wait: ciclos %0d exp 2 pending", ciclos);
    else passed++;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    total++;
    if (act !== {3'b100, W'(0)}) $display("FAIL clr_vs_expiry: got %h exp %h", act, {3'b100, W'(0)});
    else passed++;
    repeat (2) tick();
    total++;
    if (act !== {3'b010, W'(0)}) $display("FAIL clr_to_arm: got %h exp %h", act, {3'b010, W'(0)});
    else passed++;
    for (int i = 0; i < 100 && !expiry_pending(); i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (act !== {3'b100, W'(0)}) $display("FAIL stop_vs_expiry: got %h exp %h", act, {3'b100, W'(0)});
    else passed++;
    repeat (4) tick();
    total++;
    if (act !== {3'b100, W'(0)}) $display("FAIL stop_stays_idle: got %h exp %h", act, {3'b100, W'(0)});
    else passed++;
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !(m_phase == P_WAIT && m_ciclos == 2); i++) tick();
    total++;
    if ({running, ciclos} !== {1'b1, W'(2)}) $display("FAIL reset_mid_setup: got %h exp %h", {running, ciclos}, {1'b1, W'(2)});
    else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (act !== {3'b100, W'(0)}) $display("FAIL reset_mid: got %h exp %h", act, {3'b100, W'(0)});
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 9) == 0);
      stop    = ($urandom_range(0, 39) == 0);
      clr_cnt = ($urandom_range(0, 49) == 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      if (tmr_clr) tdelay = $urandom_range(1, 12);
      tick();
      total++;
      if (act !== exp_vec()) $display("FAIL random[%0d]: got %h exp %h", i, act, exp_vec());
      else passed++;
    end
    start = 1'b0; stop = 1'b0; clr_cnt = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_arm_timing();
    test_full_batch();
    test_stop_resume();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
